// File: rtl/sim_bus_host_if.sv
// Request/grant peripheral bus between an initiator (master) and a responder (slave).
// Address-phase fields are qualified by req; the response is a single rvalid pulse carrying rdata.
interface sim_bus_host_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/sim_bus_host.sv
// Bus initiator: queues valid/ready commands, issues them on req/gnt, returns one response per grant 1 cycle after rvalid.
// Command port stalls only when the FIFO is full; the response port has no backpressure; err_o flags stray rvalid or timeout.
module sim_bus_host #(
    parameter int CMD_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_addr_i,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_be_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    output logic        rsp_we_o,
    output logic [31:0] rsp_rdata_o,
    sim_bus_host_if.master bus,
    output logic        idle_o,
    output logic        err_o
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [OW-1:0] MAX_OS   = OW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] TRK_LAST = TW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t          fifo_mem [CMD_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          trk_we   [MAX_OUTSTANDING];
    logic [TW-1:0] trk_wr, trk_rd;
    logic [OW-1:0] outstanding;
    logic [CW-1:0] to_cnt;
    logic          rsp_valid_q, rsp_we_q, err_q;
    logic [31:0]   rsp_rdata_q;

    logic          empty, full, push, req, grant, rsp_take;
    cmd_t          head, cmd_in;

    function automatic logic [TW-1:0] trk_next(input logic [TW-1:0] p);
        return (p == TRK_LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push     = cmd_valid_i && !full;
    assign req      = !empty && (outstanding < MAX_OS);
    assign grant    = req && bus.gnt;
    assign rsp_take = bus.rvalid && (outstanding != '0);
    assign head     = fifo_mem[rd_ptr[AW-1:0]];
    assign cmd_in   = '{addr: cmd_addr_i, we: cmd_we_i, be: cmd_be_i, wdata: cmd_wdata_i};

    // Bus fields come straight from the FIFO head, so they cannot move until the grant pops it.
    assign bus.req   = req;
    assign bus.addr  = req ? head.addr  : '0;
    assign bus.we    = req ? head.we    : 1'b0;
    assign bus.be    = req ? head.be    : '0;
    assign bus.wdata = req ? head.wdata : '0;

    assign cmd_ready_o = !full;
    assign idle_o      = empty && (outstanding == '0);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_we_o    = rsp_we_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign err_o       = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= cmd_in;
        end
        if (!rst_i && grant) begin
            trk_we[trk_wr] <= head.we;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            trk_wr      <= '0;
            trk_rd      <= '0;
            outstanding <= '0;
            to_cnt      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + 1'b1;
            if (grant)    rd_ptr <= rd_ptr + 1'b1;
            if (grant)    trk_wr <= trk_next(trk_wr);
            if (rsp_take) trk_rd <= trk_next(trk_rd);

            case ({grant, rsp_take})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            rsp_valid_q <= rsp_take;
            if (rsp_take) begin
                rsp_we_q    <= trk_we[trk_rd];
                rsp_rdata_q <= bus.rdata;
            end

            if (bus.rvalid && (outstanding == '0)) begin
                err_q <= 1'b1;
            end

            // Timeout only flags; the stuck transaction stays outstanding and may still complete.
            if (bus.rvalid || (outstanding == '0)) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                err_q <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sim_bus_host.sv
// Directed bench for sim_bus_host: reset, single write, outstanding limit, backpressure, stray rvalid, timeout.
module tb_sim_bus_host;
    logic        clk;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_be;
    logic        rsp_valid, rsp_we;
    logic [31:0] rsp_rdata;
    logic        idle, err;
    logic        gnt_en, rvalid;
    logic [31:0] rdata;
    int          n_chk, n_err, gcnt, g0;

    sim_bus_host_if bus ();
    assign bus.gnt    = gnt_en & bus.req;
    assign bus.rvalid = rvalid;
    assign bus.rdata  = rdata;

    sim_bus_host #(
        .CMD_DEPTH      (4),
        .MAX_OUTSTANDING(2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_addr_i (cmd_addr),
        .cmd_we_i   (cmd_we),
        .cmd_be_i   (cmd_be),
        .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid),
        .rsp_we_o   (rsp_we),
        .rsp_rdata_o(rsp_rdata),
        .bus        (bus),
        .idle_o     (idle),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial gcnt = 0;
    always @(posedge clk) if (!rst && bus.req && bus.gnt) gcnt <= gcnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_addr = a; cmd_we = w; cmd_be = b; cmd_wdata = d;
    endtask

    task automatic do_reset();
        rst = 1'b1; rvalid = 1'b0; cmd_valid = 1'b0; gnt_en = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_we = 1'b0; cmd_be = '0; cmd_wdata = '0;
        gnt_en = 1'b0; rvalid = 1'b0; rdata = '0;
        repeat (2) @(posedge clk);
        cyc(); #1;
        chk("rst_req", bus.req, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_idle", idle, 1);
        chk("rst_err", err, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_addr", bus.addr, 0);
        rst = 1'b0;

        // Single write, granted immediately, rvalid one cycle after grant.
        cyc(); offer(32'h4, 1'b1, 4'hF, 32'h41); gnt_en = 1'b1; g0 = gcnt; #1;
        chk("wr_req_pre", bus.req, 0);
        cyc(); cmd_valid = 1'b0; #1;
        chk("wr_req", bus.req, 1);
        chk("wr_addr", bus.addr, 32'h4);
        chk("wr_we", bus.we, 1);
        chk("wr_be", bus.be, 4'hF);
        chk("wr_wdata", bus.wdata, 32'h41);
        cyc(); rvalid = 1'b1; rdata = 32'h0; #1;
        chk("wr_req_drop", bus.req, 0);
        chk("wr_busy", idle, 0);
        chk("wr_rspv_early", rsp_valid, 0);
        cyc(); rvalid = 1'b0; #1;
        chk("wr_rspv", rsp_valid, 1);
        chk("wr_rspwe", rsp_we, 1);
        chk("wr_idle", idle, 1);
        chk("wr_grants", gcnt - g0, 1);
        cyc(); #1;
        chk("wr_rspv_pulse", rsp_valid, 0);

        // Outstanding limit: four reads queued, at most two in flight.
        gnt_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(); offer(32'h100 + 32'(4 * i), 1'b0, 4'h3, 32'h0);
        end
        cyc(); cmd_valid = 1'b0; gnt_en = 1'b1; g0 = gcnt; #1;
        chk("ol_addr0", bus.addr, 32'h100);
        cyc(); #1;
        chk("ol_addr1", bus.addr, 32'h104);
        chk("ol_req1", bus.req, 1);
        for (int k = 0; k < 5; k++) begin
            cyc(); #1;
            chk("ol_hold_req", bus.req, 0);
        end
        chk("ol_two_grants", gcnt - g0, 2);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i > 0) begin
                chk("ol_rspv", rsp_valid, 1);
                chk("ol_rdata", rsp_rdata, 32'hA0 + 32'(i - 1));
            end
            if (i == 1) chk("ol_addr2", bus.addr, 32'h108);
            rvalid = 1'b1; rdata = 32'hA0 + 32'(i);
        end
        cyc(); rvalid = 1'b0; #1;
        chk("ol_rspv_last", rsp_valid, 1);
        chk("ol_rdata_last", rsp_rdata, 32'hA3);
        chk("ol_rspwe", rsp_we, 0);
        chk("ol_all_grants", gcnt - g0, 4);
        chk("ol_idle", idle, 1);
        chk("ol_no_err", err, 0);

        // Backpressure: no grants, five offers, four accepted.
        gnt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(); offer(32'h200 + 32'(4 * i), 1'b1, 4'h1, 32'(i)); #1;
            chk("bp_ready", cmd_ready, (i < 4) ? 1 : 0);
        end
        cyc(); cmd_valid = 1'b0; gnt_en = 1'b1; #1;
        chk("bp_full", cmd_ready, 0);
        chk("bp_head", bus.addr, 32'h200);
        cyc(); gnt_en = 1'b0; #1;
        chk("bp_ready_after", cmd_ready, 1);
        chk("bp_next_head", bus.addr, 32'h204);
        do_reset();
        chk("bp_rst_idle", idle, 1);
        chk("bp_rst_req", bus.req, 0);
        chk("bp_rst_ready", cmd_ready, 1);

        // Stray rvalid while idle.
        cyc(); rvalid = 1'b1; rdata = 32'hDEAD;
        cyc(); rvalid = 1'b0; #1;
        chk("stray_rspv", rsp_valid, 0);
        chk("stray_err", err, 1);
        cyc(); cyc(); #1;
        chk("stray_sticky", err, 1);
        do_reset();
        chk("stray_rst_err", err, 0);

        // Timeout: one grant, rvalid withheld.
        cyc(); offer(32'h300, 1'b1, 4'hF, 32'h55); gnt_en = 1'b1;
        cyc(); cmd_valid = 1'b0; #1;
        chk("to_req", bus.req, 1);
        cyc();
        for (int k = 1; k <= 8; k++) begin
            cyc(); #1;
            chk("to_err", err, (k == 8) ? 1 : 0);
        end
        cyc(); rvalid = 1'b1; rdata = 32'h77;
        cyc(); rvalid = 1'b0; #1;
        chk("to_rspv", rsp_valid, 1);
        chk("to_rspwe", rsp_we, 1);
        chk("to_rdata", rsp_rdata, 32'h77);
        cyc(); #1;
        chk("to_rdata_hold", rsp_rdata, 32'h77);
        chk("to_err_sticky", err, 1);
        chk("to_idle", idle, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
